// File: rtl/am_pkg.sv
// Alignment-marker constants for the per-lane AM lock stage:
// the 100GBASE-R M0..M2 table, the marker sync header and the lock FSM states.
package am_pkg;

  localparam int          AM_NUM = 20;
  localparam logic [1:0]  AM_SH  = 2'b10;

  // {M0,M1,M2} per PCS lane; M4..M6 are the bitwise inverse of these bytes.
  localparam logic [23:0] AM_TABLE [0:AM_NUM-1] = '{
    24'hC16821, 24'h9D718E, 24'h594BE8, 24'h4D957B, 24'hF50709,
    24'hDD14C2, 24'h9A4A26, 24'h7B4566, 24'hA02476, 24'h68C9FB,
    24'hFD6C99, 24'hB99155, 24'h5CB9B2, 24'h1AF8BD, 24'h83C7CA,
    24'h3536CD, 24'hC4314C, 24'hADD6B7, 24'h5F662A, 24'hC0F0E5
  };

  typedef enum logic [1:0] {
    ST_FIND_1ST = 2'd0,
    ST_COUNT    = 2'd1,
    ST_LOCKED   = 2'd2
  } am_state_t;

  // BIP3/BIP7 are deliberately excluded from the comparison.
  function automatic logic am_fields_match(input logic [65:0] blk, input logic [23:0] pat);
    return (blk[65:64] == AM_SH) && (blk[63:40] == pat) && (blk[31:8] == ~pat);
  endfunction

endpackage

// File: rtl/am_match.sv
// Combinational alignment-marker comparator: flags a marker block and returns
// the lowest matching lane index among the first N_ALIGNER table entries.
module am_match
  import am_pkg::*;
#(
  parameter int NB_DATA    = 66,
  parameter int N_ALIGNER  = 20,
  parameter int NB_LANE_ID = 5
) (
  input  logic [NB_DATA-1:0]    data,
  output logic                  match,
  output logic [NB_LANE_ID-1:0] lane
);

  localparam int N_CMP = (N_ALIGNER < AM_NUM) ? N_ALIGNER : AM_NUM;

  logic [N_CMP-1:0] hit;

  for (genvar k = 0; k < N_CMP; k++) begin : g_cmp
    assign hit[k] = am_fields_match(data[65:0], AM_TABLE[k]);
  end

  assign match = |hit;

  // Scan downwards so the lowest matching index is the one left in lane.
  always_comb begin
    lane = '0;
    for (int k = N_CMP - 1; k >= 0; k--) begin
      lane = hit[k] ? NB_LANE_ID'(k) : lane;
    end
  end

endmodule

// File: rtl/am_lock_fsm.sv
// Per-lane alignment-marker lock: find a marker, confirm it one period later,
// then track it, dropping lock after MAX_INV_AM bad markers in a row.
// Optional AM_LOCK_LOSS_CNT_EN adds a saturating lock-loss counter output.
module am_lock_fsm
  import am_pkg::*;
#(
  parameter int NB_DATA     = 66,
  parameter int N_ALIGNER   = 20,
  parameter int NB_LANE_ID  = 5,
  parameter int AM_PERIOD   = 16384,
  parameter int NB_AM_COUNT = $clog2(AM_PERIOD),
  parameter int MAX_INV_AM  = 4
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic                  i_enable,
  input  logic                  i_valid,
  input  logic [NB_DATA-1:0]    i_data,
  output logic [NB_DATA-1:0]    o_data,
  output logic                  o_valid,
  output logic                  o_lock,
  output logic [NB_LANE_ID-1:0] o_lane_id,
  output logic                  o_start_of_lane,
  output logic                  o_am_flag,
  output logic                  o_resync
`ifdef AM_LOCK_LOSS_CNT_EN
  ,
  output logic [7:0]            o_lock_loss_count
`endif
);

  localparam int                     NB_INV   = $clog2(MAX_INV_AM + 1);
  localparam logic [NB_AM_COUNT-1:0] AM_LAST  = NB_AM_COUNT'(AM_PERIOD - 1);
  localparam logic [NB_INV-1:0]      INV_LAST = NB_INV'(MAX_INV_AM - 1);

  am_state_t             state;
  logic [NB_AM_COUNT-1:0] am_count;
  logic [NB_INV-1:0]      inv_count;
  logic [NB_LANE_ID-1:0]  lane_id;
  logic                   match;
  logic [NB_LANE_ID-1:0]  match_lane;
  logic                   at_eval;
  logic                   same_lane;

  am_match #(
    .NB_DATA    (NB_DATA),
    .N_ALIGNER  (N_ALIGNER),
    .NB_LANE_ID (NB_LANE_ID)
  ) u_am_match (
    .data  (i_data),
    .match (match),
    .lane  (match_lane)
  );

  assign at_eval   = (am_count == AM_LAST);
  assign same_lane = match && (match_lane == lane_id);

  // Lock FSM, period/invalid counters and all registered outputs.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state           <= ST_FIND_1ST;
      am_count        <= '0;
      inv_count       <= '0;
      lane_id         <= '0;
      o_data          <= '0;
      o_valid         <= 1'b0;
      o_lock          <= 1'b0;
      o_lane_id       <= '0;
      o_start_of_lane <= 1'b0;
      o_am_flag       <= 1'b0;
      o_resync        <= 1'b0;
    end else begin
      o_data          <= i_data;
      o_valid         <= i_valid;
      o_start_of_lane <= 1'b0;
      o_am_flag       <= 1'b0;
      o_resync        <= 1'b0;
      if (!i_enable) begin
        // Disable is a silent return to search: no resync, any match ignored.
        state     <= ST_FIND_1ST;
        am_count  <= '0;
        inv_count <= '0;
        o_lock    <= 1'b0;
        o_lane_id <= '0;
      end else if (i_valid) begin
        case (state)
          ST_FIND_1ST: begin
            if (match) begin
              lane_id   <= match_lane;
              am_count  <= '0;
              state     <= ST_COUNT;
              o_am_flag <= 1'b1;
            end else begin
              state <= ST_FIND_1ST;
            end
          end
          ST_COUNT: begin
            o_am_flag <= match;
            if (at_eval) begin
              am_count <= '0;
              if (same_lane) begin
                state           <= ST_LOCKED;
                inv_count       <= '0;
                o_lock          <= 1'b1;
                o_lane_id       <= lane_id;
                o_start_of_lane <= 1'b1;
              end else begin
                // Failed confirmation: restart the search from the next block.
                state <= ST_FIND_1ST;
              end
            end else begin
              am_count <= am_count + NB_AM_COUNT'(1);
            end
          end
          ST_LOCKED: begin
            o_am_flag <= match | at_eval;
            if (at_eval) begin
              am_count <= '0;
              if (same_lane) begin
                inv_count       <= '0;
                o_start_of_lane <= 1'b1;
              end else if (inv_count == INV_LAST) begin
                state     <= ST_FIND_1ST;
                inv_count <= '0;
                o_lock    <= 1'b0;
                o_lane_id <= '0;
                o_resync  <= 1'b1;
              end else begin
                inv_count <= inv_count + NB_INV'(1);
              end
            end else begin
              am_count <= am_count + NB_AM_COUNT'(1);
            end
          end
          default: begin
            state     <= ST_FIND_1ST;
            am_count  <= '0;
            inv_count <= '0;
            o_lock    <= 1'b0;
            o_lane_id <= '0;
          end
        endcase
      end else begin
        state <= state;
      end
    end
  end

`ifdef AM_LOCK_LOSS_CNT_EN
  // Saturating tally of resync pulses; only reset clears it.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      o_lock_loss_count <= 8'd0;
    end else if (o_resync && (o_lock_loss_count != 8'hFF)) begin
      o_lock_loss_count <= o_lock_loss_count + 8'd1;
    end else begin
      o_lock_loss_count <= o_lock_loss_count;
    end
  end
`endif

endmodule

// File: tb/tb_am_lock_fsm.sv
// Bench for am_lock_fsm (AM_PERIOD=16): directed scenarios plus random traffic,
// every output compared against a valid-block-index model of the lock rules.
module tb_am_lock_fsm;

  localparam int P    = 16;
  localparam int MAXI = 4;
  localparam int SEARCH = 0, ARMED = 1, LOCKD = 2;

  localparam logic [23:0] TBL [0:19] = '{
    24'hC16821, 24'h9D718E, 24'h594BE8, 24'h4D957B, 24'hF50709,
    24'hDD14C2, 24'h9A4A26, 24'h7B4566, 24'hA02476, 24'h68C9FB,
    24'hFD6C99, 24'hB99155, 24'h5CB9B2, 24'h1AF8BD, 24'h83C7CA,
    24'h3536CD, 24'hC4314C, 24'hADD6B7, 24'h5F662A, 24'hC0F0E5
  };

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en  = 1'b0;
  logic        vld = 1'b0;
  logic [65:0] din = '0;
  logic [65:0] o_data;
  logic        o_valid, o_lock, o_start_of_lane, o_am_flag, o_resync;
  logic [4:0]  o_lane_id;
`ifdef AM_LOCK_LOSS_CNT_EN
  logic [7:0]  o_lock_loss_count;
`endif

  int errors = 0;
  int checks = 0;

  // model state: positions are absolute indices of enabled valid blocks
  int          mode, vi, next_at, mlane, bad;
  logic        lk;
  logic [4:0]  lid;
  logic [65:0] exp_data;
  logic [9:0]  expv;

  wire [9:0] obs = {o_valid, o_lock, o_lane_id, o_start_of_lane, o_am_flag, o_resync};

  always #5 clk = ~clk;

  am_lock_fsm #(.AM_PERIOD(P), .MAX_INV_AM(MAXI)) dut (
    .i_clock         (clk),
    .i_reset         (rst),
    .i_enable        (en),
    .i_valid         (vld),
    .i_data          (din),
    .o_data          (o_data),
    .o_valid         (o_valid),
    .o_lock          (o_lock),
    .o_lane_id       (o_lane_id),
    .o_start_of_lane (o_start_of_lane),
    .o_am_flag       (o_am_flag),
    .o_resync        (o_resync)
`ifdef AM_LOCK_LOSS_CNT_EN
    , .o_lock_loss_count (o_lock_loss_count)
`endif
  );

  function automatic int ref_lane(input logic [65:0] d);
    for (int k = 0; k < 20; k++)
      if (d[65:64] == 2'b10 && d[63:40] == TBL[k] && d[31:8] == ~TBL[k]) return k;
    return -1;
  endfunction

  function automatic logic [65:0] rnd_blk();
    logic [95:0] r;
    r = {$urandom(), $urandom(), $urandom()};
    return r[65:0];
  endfunction

  function automatic logic [65:0] mk_am(input int lane, input bit corrupt);
    logic [23:0] p, q;
    p = TBL[lane];
    q = ~p;
    if (corrupt) q[5] = ~q[5];
    return {2'b10, p, 8'($urandom()), q, 8'($urandom())};
  endfunction

  task automatic model_reset();
    mode = SEARCH; vi = 0; next_at = 0; mlane = 0; bad = 0;
    lk = 1'b0; lid = 5'd0; exp_data = '0; expv = '0;
  endtask

  task automatic model_step(input logic e, input logic v, input logic [65:0] d);
    int  k;
    logic sol, rs, fl;
    sol = 1'b0; rs = 1'b0; fl = 1'b0;
    k = ref_lane(d);
    if (!e) begin
      mode = SEARCH; lk = 1'b0; lid = 5'd0;
    end else if (v) begin
      vi++;
      if (mode == SEARCH) begin
        if (k >= 0) begin mode = ARMED; mlane = k; next_at = vi + P; fl = 1'b1; end
      end else begin
        fl = (k >= 0) || (mode == LOCKD && vi == next_at);
        if (vi == next_at) begin
          next_at = vi + P;
          if (mode == ARMED) begin
            if (k == mlane) begin mode = LOCKD; lk = 1'b1; lid = 5'(mlane); sol = 1'b1; bad = 0; end
            else mode = SEARCH;
          end else if (k == mlane) begin
            bad = 0; sol = 1'b1;
          end else begin
            bad++;
            if (bad == MAXI) begin mode = SEARCH; lk = 1'b0; lid = 5'd0; rs = 1'b1; bad = 0; end
          end
        end
      end
    end
    exp_data = d;
    expv = {v, lk, lid, sol, fl, rs};
  endtask

  task automatic drive(input logic e, input logic v, input logic [65:0] d);
    en = e; vld = v; din = d;
    @(posedge clk);
    model_step(e, v, d);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b0; vld = 1'b0; din = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({o_data, obs} !== 76'd0) begin
      errors++; $display("FAIL reset got=%h/%h exp=0", o_data, obs);
    end
`ifdef AM_LOCK_LOSS_CNT_EN
    checks++;
    if (o_lock_loss_count !== 8'd0) begin
      errors++; $display("FAIL reset_loss_cnt got=%0d exp=0", o_lock_loss_count);
    end
`endif
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_lock_lane0();
    drive(1'b0, 1'b1, rnd_blk());
    for (int b = 0; b <= P; b++) begin
      drive(1'b1, 1'b1, (b % P == 0) ? mk_am(0, 1'b0) : rnd_blk());
      checks++;
      if ({o_data, obs} !== {exp_data, expv}) begin
        errors++; $display("FAIL lock_lane0 b=%0d got=%h/%h exp=%h/%h", b, o_data, obs, exp_data, expv);
      end
    end
    checks++;
    if ({o_lock, o_lane_id, o_start_of_lane} !== 7'b1_00000_1) begin
      errors++; $display("FAIL lock_lane0_final got lock=%b id=%0d sol=%b exp 1/0/1", o_lock, o_lane_id, o_start_of_lane);
    end
    drive(1'b1, 1'b1, rnd_blk());
    checks++;
    if ({o_lock, o_start_of_lane} !== 2'b10) begin
      errors++; $display("FAIL lock_lane0_after got lock=%b sol=%b exp 1/0", o_lock, o_start_of_lane);
    end
  endtask

  task automatic test_wrong_lane();
    drive(1'b0, 1'b1, rnd_blk());
    for (int b = 0; b <= 2 * P; b++) begin
      drive(1'b1, 1'b1, (b == 0) ? mk_am(5, 1'b0) : (b % P == 0) ? mk_am(7, 1'b0) : rnd_blk());
      checks++;
      if ({o_data, obs} !== {exp_data, expv}) begin
        errors++; $display("FAIL wrong_lane b=%0d got=%h/%h exp=%h/%h", b, o_data, obs, exp_data, expv);
      end
      if (b == P || b == 2 * P) begin
        checks++;
        if ({o_lock, o_start_of_lane, o_am_flag} !== 3'b001) begin
          errors++; $display("FAIL wrong_lane_nolock b=%0d got lock=%b sol=%b flag=%b exp 0/0/1", b, o_lock, o_start_of_lane, o_am_flag);
        end
      end
    end
  endtask

  task automatic test_invalid_markers();
    bit plan [8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    drive(1'b0, 1'b1, rnd_blk());
    for (int b = 0; b <= P; b++) begin
      drive(1'b1, 1'b1, (b % P == 0) ? mk_am(3, 1'b0) : rnd_blk());
      checks++;
      if ({o_data, obs} !== {exp_data, expv}) begin
        errors++; $display("FAIL inv_lock b=%0d got=%h/%h exp=%h/%h", b, o_data, obs, exp_data, expv);
      end
    end
    for (int p = 0; p < 8; p++) begin
      for (int b = 1; b <= P; b++) begin
        drive(1'b1, 1'b1, (b == P) ? mk_am(3, plan[p]) : rnd_blk());
        checks++;
        if ({o_data, obs} !== {exp_data, expv}) begin
          errors++; $display("FAIL inv_period p=%0d b=%0d got=%h/%h exp=%h/%h", p, b, o_data, obs, exp_data, expv);
        end
      end
      if (p == 3 || p == 6) begin
        checks++;
        if ({o_lock, o_resync, o_lane_id} !== {2'b10, 5'd3}) begin
          errors++; $display("FAIL inv_held p=%0d got lock=%b rs=%b id=%0d exp 1/0/3", p, o_lock, o_resync, o_lane_id);
        end
      end
      if (p == 7) begin
        checks++;
        if ({o_lock, o_resync, o_start_of_lane} !== 3'b010) begin
          errors++; $display("FAIL inv_drop got lock=%b rs=%b sol=%b exp 0/1/0", o_lock, o_resync, o_start_of_lane);
        end
      end
    end
    drive(1'b1, 1'b1, rnd_blk());
    checks++;
    if ({o_lock, o_resync} !== 2'b00) begin
      errors++; $display("FAIL inv_pulse_end got lock=%b rs=%b exp 0/0", o_lock, o_resync);
    end
  endtask

  task automatic test_valid_gaps();
    drive(1'b0, 1'b1, rnd_blk());
    for (int b = 0; b <= P; b++) begin
      drive(1'b1, 1'b1, (b % P == 0) ? mk_am(9, 1'b0) : rnd_blk());
      checks++;
      if ({o_data, obs} !== {exp_data, expv}) begin
        errors++; $display("FAIL gaps_lock b=%0d got=%h/%h exp=%h/%h", b, o_data, obs, exp_data, expv);
      end
    end
    for (int b = 1; b <= P; b++) begin
      if (b == 8) begin
        for (int g = 0; g < 5; g++) begin
          drive(1'b1, 1'b0, (g == 2) ? mk_am(9, 1'b0) : rnd_blk());
          checks++;
          if ({o_data, obs} !== {exp_data, expv}) begin
            errors++; $display("FAIL gaps_idle g=%0d got=%h/%h exp=%h/%h", g, o_data, obs, exp_data, expv);
          end
        end
      end
      drive(1'b1, 1'b1, (b == P) ? mk_am(9, 1'b0) : rnd_blk());
      checks++;
      if ({o_data, obs} !== {exp_data, expv}) begin
        errors++; $display("FAIL gaps b=%0d got=%h/%h exp=%h/%h", b, o_data, obs, exp_data, expv);
      end
    end
    checks++;
    if ({o_lock, o_start_of_lane, o_lane_id} !== {2'b11, 5'd9}) begin
      errors++; $display("FAIL gaps_sol got lock=%b sol=%b id=%0d exp 1/1/9", o_lock, o_start_of_lane, o_lane_id);
    end
  endtask

  task automatic test_enable_override();
    drive(1'b0, 1'b1, rnd_blk());
    for (int b = 0; b <= 2 * P; b++) begin
      drive((b != 2 * P), 1'b1, (b % P == 0) ? mk_am(2, 1'b0) : rnd_blk());
      checks++;
      if ({o_data, obs} !== {exp_data, expv}) begin
        errors++; $display("FAIL enable b=%0d got=%h/%h exp=%h/%h", b, o_data, obs, exp_data, expv);
      end
    end
    checks++;
    if ({o_lock, o_start_of_lane, o_resync, o_am_flag} !== 4'b0000) begin
      errors++; $display("FAIL enable_off got lock=%b sol=%b rs=%b flag=%b exp 0000", o_lock, o_start_of_lane, o_resync, o_am_flag);
    end
  endtask

  task automatic test_async_reset();
    drive(1'b0, 1'b1, rnd_blk());
    for (int b = 0; b <= P; b++) drive(1'b1, 1'b1, (b % P == 0) ? mk_am(12, 1'b0) : rnd_blk());
    checks++;
    if (o_lock !== 1'b1) begin
      errors++; $display("FAIL areset_pre got lock=%b exp 1", o_lock);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({o_data, obs} !== 76'd0) begin
      errors++; $display("FAIL areset_now got=%h/%h exp=0", o_data, obs);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
    for (int b = 0; b <= P; b++) begin
      drive(1'b1, 1'b1, (b % P == 0) ? mk_am(12, 1'b0) : rnd_blk());
      checks++;
      if ({o_data, obs} !== {exp_data, expv}) begin
        errors++; $display("FAIL areset_relock b=%0d got=%h/%h exp=%h/%h", b, o_data, obs, exp_data, expv);
      end
    end
    checks++;
    if ({o_lock, o_lane_id} !== {1'b1, 5'd12}) begin
      errors++; $display("FAIL areset_final got lock=%b id=%0d exp 1/12", o_lock, o_lane_id);
    end
  endtask

  task automatic test_random();
    int   ph, lane, r;
    logic e, v;
    logic [65:0] d;
    ph = 0;
    lane = $urandom_range(0, 19);
    for (int c = 0; c < 4000; c++) begin
      e = ($urandom_range(0, 299) != 0);
      v = ($urandom_range(0, 7) != 0);
      if (v && (ph % P == 0)) begin
        r = $urandom_range(0, 99);
        d = (r < 85) ? mk_am(lane, 1'b0) : (r < 94) ? mk_am(lane, 1'b1) : mk_am((lane + 1) % 20, 1'b0);
      end else begin
        d = rnd_blk();
      end
      if (v) ph++;
      if ($urandom_range(0, 799) == 0) lane = $urandom_range(0, 19);
      drive(e, v, d);
      checks++;
      if ({o_data, obs} !== {exp_data, expv}) begin
        errors++; $display("FAIL random c=%0d got=%h/%h exp=%h/%h", c, o_data, obs, exp_data, expv);
      end
    end
  endtask

`ifdef AM_LOCK_LOSS_CNT_EN
  task automatic test_loss_count();
    int expc;
    drive(1'b0, 1'b1, rnd_blk());
    for (int i = 0; i < 300; i++) begin
      for (int b = 0; b <= P; b++) begin
        drive(1'b1, 1'b1, (b % P == 0) ? mk_am(i % 20, 1'b0) : rnd_blk());
        if (b == 0 && (i % 50 == 1 || i == 255 || i == 256)) begin
          expc = (i > 255) ? 255 : i;
          checks++;
          if (o_lock_loss_count !== 8'(expc)) begin
            errors++; $display("FAIL loss_cnt i=%0d got=%0d exp=%0d", i, o_lock_loss_count, expc);
          end
        end
      end
      for (int b = 1; b <= MAXI * P; b++) drive(1'b1, 1'b1, (b % P == 0) ? mk_am(i % 20, 1'b1) : rnd_blk());
    end
    drive(1'b1, 1'b1, rnd_blk());
    checks++;
    if (o_lock_loss_count !== 8'd255) begin
      errors++; $display("FAIL loss_cnt_sat got=%0d exp=255", o_lock_loss_count);
    end
  endtask
`endif

  initial begin
    model_reset();
    test_reset();
    test_lock_lane0();
    test_wrong_lane();
    test_invalid_markers();
    test_valid_gaps();
    test_enable_override();
    test_async_reset();
    test_random();
`ifdef AM_LOCK_LOSS_CNT_EN
    test_loss_count();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/am_lock_fsm.md
Name: am_lock_fsm

Overview:
- Per-lane alignment-marker lock stage. One instance per PCS lane (N_LANES in parallel), between block lock and the deskew stage.
- Searches the 66b block stream for any of the 20 100GBASE-R alignment markers and acquires lock on two matches exactly AM_PERIOD blocks apart.
- Reports the lane ID and flags every marker position. Its o_start_of_lane / o_resync feed the deskew start_of_lane / resync inputs.

Parameters:
- NB_DATA, 66, block width incl. sync header.
- N_ALIGNER, 20, number of valid AM patterns / lanes.
- NB_LANE_ID, 5, width of lane ID (clog2(N_ALIGNER)).
- AM_PERIOD, 16384, blocks between markers. Reduced, e.g. 16, for simulation.
- NB_AM_COUNT, $clog2(AM_PERIOD), period counter width.
- MAX_INV_AM, 4, consecutive bad markers that drop lock.

Ports:
- i_clock  in  1  block clock.
- i_reset  in  1  asynchronous, active-high reset.
- i_enable  in  1  stage enable. Low forces search state synchronously.
- i_valid  in  1  block qualifier. All counting and matching occurs only when high.
- i_data  in  NB_DATA  block: [65:64] sync header, [63:56] M0, [55:48] M1, [47:40] M2, [39:32] BIP3, [31:24] M4, [23:16] M5, [15:8] M6, [7:0] BIP7.
- o_data  out  NB_DATA  i_data delayed 1 cycle.
- o_valid  out  1  i_valid delayed 1 cycle.
- o_lock  out  1  AM lock acquired.
- o_lane_id  out  NB_LANE_ID  matched PCS lane number. Valid while o_lock.
- o_start_of_lane  out  1  one-cycle pulse aligned with o_data carrying a marker while locked.
- o_am_flag  out  1  o_data is a marker block: any matching or expected position while locked, for downstream AM removal.
- o_resync  out  1  one-cycle pulse on lock loss.

Behaviour:
- Reset values: all outputs 0, state FIND_1ST, counters 0, stored ID 0.
- Latency: 1 cycle for all outputs.
- Match rule: sync header == 2'b10, {M0,M1,M2} equals table entry k, and {M4,M5,M6} equals bitwise inverse. BIP bytes are ignored. Lowest matching k wins. k < N_ALIGNER only.
- States:
  - FIND_1ST: on valid match k, store k, clear counter, go to COUNT.
  - COUNT: counter increments per valid block. When counter == AM_PERIOD-1 and the next valid block arrives, evaluate it. The next state depends on the current state:
    - From COUNT (first lock attempt): match with same k → LOCKED, o_lock=1, o_start_of_lane pulse. Otherwise → FIND_1ST, with no slip and the block not re-searched.
    - From LOCKED: match with stored k → clear invalid count, pulse o_start_of_lane. Otherwise increment invalid count. If the count reaches MAX_INV_AM → FIND_1ST, o_lock=0, o_resync pulse the same cycle, counters cleared.
  - The counter wraps to 0 at each evaluation (NB_AM_COUNT bits, modulo AM_PERIOD).
- A different valid k in LOCKED counts as invalid. It never re-targets the ID.
- i_valid low: state, counters and o_start_of_lane frozen/0. o_data still registered.
- i_enable low: next edge returns to FIND_1ST, o_lock=0. No o_resync pulse, since no lock loss has been signalled. This overrides any simultaneous match.
- Reset mid-operation clears everything asynchronously. No pulses are generated.

Optional Feature:
- Macro AM_LOCK_LOSS_CNT_EN.
- Defined: adds output o_lock_loss_count [7:0], a saturating count of o_resync pulses (holds at 255), cleared only by reset.
- Undefined: port and logic are absent.

Decomposition:
- Package am_pkg holds the N_ALIGNER x 24-bit AM table (IEEE 802.3 Table 82-2 M0..M2 values), AM_SH=2'b10, and the state encoding localparams.
- One natural sub-module, am_match: combinational comparator returning match flag and lane index.
- The FSM and counters stay in am_lock_fsm.

Test Plan (AM_PERIOD=16):
- Lane-0 marker (C1 68 21 / 3E 97 DE) at block 0 and block 16 → o_lock rises 1 cycle after block 16, o_lane_id=0, o_start_of_lane pulse.
- Lane-5 marker then lane-7 marker 16 blocks later → no lock, back to FIND_1ST. Lane 7 at the following 16-block point alone does not lock.
- Locked on lane 3; corrupt 3 consecutive markers then a good one → lock held, invalid count cleared. Corrupt 4 → o_lock=0 and o_resync pulse after the 4th.
- Locked; toggle i_valid low for 5 cycles within a period → marker still detected on the 16th valid block, not the 16th clock.
- Assert i_reset asynchronously while locked → all outputs 0 immediately. Deassert and re-feed markers → relock after 2 markers.
- Macro on: force 300 lock losses → o_lock_loss_count=255.
